// File: rtl/mult_job_sequencer_pkg.sv
// Shared definitions for the multiply job sequencer: FSM states and product width.
package mult_job_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_STALL
    } seq_state_t;

    // Product of two w-bit operands needs 2*w bits.
    function automatic int unsigned product_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Bundles the operand stream, product stream and multiplier-side signals.
interface mult_job_sequencer_if
    import mult_job_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();
    localparam int unsigned PW = product_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic             mult_start;
    logic             mult_done;
    logic [PW-1:0]    mult_product;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_product;
    logic             busy;

    // Environment side: producer, consumer and multiplier control/datapath.
    modport master (
        output in_valid, in_a, in_b, mult_done, mult_product, out_ready,
        input  in_ready, mult_a, mult_b, mult_start, out_valid, out_product, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, mult_done, mult_product, out_ready,
        output in_ready, mult_a, mult_b, mult_start, out_valid, out_product, busy
    );
endinterface

// File: rtl/mult_job_sequencer_operand_fifo.sv
// Small power-of-two FIFO holding packed {a, b} operand pairs.
module mult_operand_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/mult_job_sequencer.sv
// Front end for the shift-add multiplier: buffers operand pairs, issues one
// job at a time and holds each product on a valid/ready output stream.
module mult_job_sequencer
    import mult_job_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    mult_job_sequencer_if.slave bus
);
    localparam int unsigned PW = product_width(WIDTH);

    seq_state_t       state;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PW-1:0]    fifo_head;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic [WIDTH-1:0] mult_a_q;
    logic [WIDTH-1:0] mult_b_q;
    logic             mult_start_q;
    logic             out_valid_q;
    logic [PW-1:0]    out_product_q;

    assign push      = bus.in_valid && !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign slot_free = !out_valid_q || bus.out_ready;

    mult_operand_fifo #(
        .DATA_W     (PW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.in_a, bus.in_b}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Job FSM with registered operand, start and output-slot registers.
    // A drain and a capture in the same cycle: the later out_valid write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            mult_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            mult_start_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mult_a_q     <= fifo_head[PW-1 -: WIDTH];
                        mult_b_q     <= fifo_head[WIDTH-1:0];
                        mult_start_q <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mult_done) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE, ST_STALL: begin
                    if (slot_free) begin
                        out_product_q <= bus.mult_product;
                        out_valid_q   <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        state <= ST_STALL;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.mult_a      = mult_a_q;
    assign bus.mult_b      = mult_b_q;
    assign bus.mult_start  = mult_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.busy        = (state != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed and random bench for mult_job_sequencer with a behavioural
// multiplier responder and an in-order product scoreboard.
module tb_mult_job_sequencer;
    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_job_sequencer_if #(.WIDTH(W)) bus ();

    mult_job_sequencer #(
        .WIDTH      (W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned    checks = 0;
    int unsigned    errors = 0;
    int unsigned    cyc    = 0;
    logic [PW-1:0]  exp_q[$];

    // multiplier responder state
    bit             m_active = 1'b0;
    int unsigned    m_cnt    = 0;
    logic [W-1:0]   m_a, m_b;
    int unsigned    n_starts = 0;
    int unsigned    ov_rise_cyc = 0;
    bit             prev_ov = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: account handshakes seen before the edge, then model the multiplier.
    task automatic tick();
        bit push_ok;
        bit pop_ok;
        logic [PW-1:0] prod;
        push_ok = bus.in_valid && bus.in_ready;
        pop_ok  = bus.out_valid && bus.out_ready;
        prod    = bus.out_product;
        if (!rst && push_ok) exp_q.push_back(PW'(bus.in_a) * PW'(bus.in_b));
        if (!rst && pop_ok) begin
            if (exp_q.size() == 0) chk("spurious_output", 32'(pop_ok), 32'd0);
            else                   chk("out_product", 32'(prod), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_active      = 1'b0;
            bus.mult_done = 1'b0;
        end else begin
            if (m_active) begin
                m_cnt++;
                if (m_cnt <= 2 * W + 2) begin
                    chk("mult_a_stable", 32'(bus.mult_a), 32'(m_a));
                    chk("mult_b_stable", 32'(bus.mult_b), 32'(m_b));
                end
                if (m_cnt == 2 * W + 2) begin
                    bus.mult_done    = 1'b1;
                    bus.mult_product = ~(PW'(m_a) * PW'(m_b));
                end else if (m_cnt == 2 * W + 3) begin
                    bus.mult_done    = 1'b0;
                    bus.mult_product = PW'(m_a) * PW'(m_b);
                    m_active         = 1'b0;
                end
            end
            if (bus.mult_start) begin
                chk("start_no_overlap", 32'(m_active), 32'd0);
                m_active = 1'b1;
                m_cnt    = 0;
                m_a      = bus.mult_a;
                m_b      = bus.mult_b;
                n_starts++;
            end
        end
        if (bus.out_valid && !prev_ov) ov_rise_cyc = cyc;
        prev_ov = bus.out_valid;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned n;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.busy || bus.out_valid) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_busy", 32'(bus.busy), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_all_results", exp_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned t0;
        int unsigned s0;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.out_ready    = 1'b1;
        bus.mult_done    = 1'b0;
        bus.mult_product = '0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_product", 32'(bus.out_product), 32'd0);
        chk("rst_mult_a", 32'(bus.mult_a), 32'd0);
        chk("rst_mult_b", 32'(bus.mult_b), 32'd0);
        chk("rst_mult_start", 32'(bus.mult_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        // single job latency: 3*5
        s0 = n_starts;
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd3;
        bus.in_b     = 4'd5;
        tick();
        t0 = cyc;
        bus.in_valid = 1'b0;
        tick();
        chk("start_at_t1", 32'(bus.mult_start), 32'd1);
        tick();
        chk("start_one_cycle", 32'(bus.mult_start), 32'd0);
        while (cyc < t0 + 13) tick();
        chk("single_out_valid", 32'(bus.out_valid), 32'd1);
        chk("single_out_product", 32'(bus.out_product), 32'd15);
        chk("single_latency", ov_rise_cyc, t0 + 13);
        tick();
        chk("single_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("single_start_count", n_starts - s0, 32'd1);
        drain();

        // boundary operands, one job at a time
        push_pair(4'd15, 4'd15); drain();
        push_pair(4'd0,  4'd9);  drain();
        push_pair(4'd9,  4'd0);  drain();
        push_pair(4'd1,  4'd15); drain();

        // back-to-back pushes; the FIFO fills while the first job runs
        push_pair(4'd2, 4'd7);
        push_pair(4'd4, 4'd4);
        push_pair(4'd6, 4'd3);
        chk("b2b_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        drain();

        // back-pressure: second product waits behind the first
        bus.out_ready = 1'b0;
        push_pair(4'd2, 4'd3);
        push_pair(4'd5, 4'd5);
        repeat (50) tick();
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_out_product_held", 32'(bus.out_product), 32'd6);
        chk("bp_busy_stalled", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_reload_product", 32'(bus.out_product), 32'd25);
        tick();
        drain();

        // reset during WAIT of 7*7, then a stray done
        push_pair(4'd7, 4'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        bus.mult_done    = 1'b1;
        bus.mult_product = 8'd49;
        tick();
        bus.mult_done = 1'b0;
        repeat (20) tick();
        chk("stray_done_no_output", 32'(bus.out_valid), 32'd0);
        chk("stray_done_idle", 32'(bus.busy), 32'd0);

        // random traffic with random back-pressure
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) == 0);
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
